// File: rtl/mem_resp_stage.sv
// mem_resp_stage: memory-response stage; waits for cache data, aligns/extends loads,
// and drops responses that belong to requests killed by a flush.
module mem_resp_stage #(
    parameter int DISCARD_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_result,
    input  logic [4:0]  es_dest,
    input  logic        es_gr_we,
    input  logic        es_mem_req,
    input  logic        es_load_op,
    input  logic [1:0]  es_mem_size,
    input  logic        es_load_sign,
    input  logic        es_excp,
    input  logic [15:0] es_excp_num,
    input  logic        es_req_inflight,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [4:0]  ms_dest,
    output logic        ms_gr_we,
    output logic        ms_excp,
    output logic [15:0] ms_excp_num,
    output logic [31:0] ms_final_result,
    output logic        ms_fwd_valid,
    output logic        ms_fwd_blocked
);
    logic                 ms_valid, ms_mem_req, ms_load_op, ms_load_sign, data_buf_valid;
    logic [1:0]           ms_mem_size;
    logic [31:0]          ms_result, data_buf, load_src, load_sh, load_data;
    logic [DISCARD_W-1:0] discard_cnt;
    logic [DISCARD_W:0]   cnt_sum;
    logic                 wait_data, resp_mine, ms_ready_go, handoff, latch;

    assign wait_data      = ms_valid && ms_mem_req && !ms_excp;
    assign resp_mine      = data_data_ok && discard_cnt == '0;
    assign ms_ready_go    = !wait_data || data_buf_valid || resp_mine;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign handoff        = ms_to_ws_valid && ws_allowin;
    assign latch          = es_to_ms_valid && ms_allowin && !flush;
    assign ms_fwd_valid   = ms_valid && ms_gr_we;
    assign ms_fwd_blocked = ms_valid && ms_load_op && !ms_excp && !ms_ready_go;

    // Each flushed request still owed a response bumps the count; every response seen while nonzero is eaten.
    assign cnt_sum = (DISCARD_W+1)'(discard_cnt)
                   + (DISCARD_W+1)'(flush && wait_data && !data_buf_valid && !data_data_ok)
                   + (DISCARD_W+1)'(flush && es_req_inflight)
                   - (DISCARD_W+1)'(data_data_ok && discard_cnt != '0);

    assign load_src  = data_buf_valid ? data_buf : data_rdata;
    assign load_sh   = load_src >> {ms_result[1:0], 3'b000};
    assign load_data = ms_mem_size == 2'd0 ? {{24{ms_load_sign && load_sh[7]}}, load_sh[7:0]} :
                       ms_mem_size == 2'd1 ? {{16{ms_load_sign && load_sh[15]}}, load_sh[15:0]} :
                       load_src;
    assign ms_final_result = ms_load_op && !ms_excp ? load_data : ms_result;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid       <= 1'b0;
            data_buf_valid <= 1'b0;
            data_buf       <= '0;
            discard_cnt    <= '0;
            ms_pc          <= '0;
            ms_result      <= '0;
            ms_dest        <= '0;
            ms_gr_we       <= 1'b0;
            ms_mem_req     <= 1'b0;
            ms_load_op     <= 1'b0;
            ms_mem_size    <= '0;
            ms_load_sign   <= 1'b0;
            ms_excp        <= 1'b0;
            ms_excp_num    <= '0;
        end else begin
            ms_valid    <= flush ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid;
            discard_cnt <= cnt_sum[DISCARD_W-1:0];
            if (latch) begin
                ms_pc        <= es_pc;
                ms_result    <= es_result;
                ms_dest      <= es_dest;
                ms_gr_we     <= es_gr_we;
                ms_mem_req   <= es_mem_req;
                ms_load_op   <= es_load_op;
                ms_mem_size  <= es_mem_size;
                ms_load_sign <= es_load_sign;
                ms_excp      <= es_excp;
                ms_excp_num  <= es_excp_num;
            end
            if (flush || handoff)
                data_buf_valid <= 1'b0;
            else if (wait_data && resp_mine && !data_buf_valid && !ws_allowin) begin
                data_buf_valid <= 1'b1;
                data_buf       <= data_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            assert (!cnt_sum[DISCARD_W]);
    end
endmodule

// File: tb/tb_mem_resp_stage.sv
// tb_mem_resp_stage: directed vectors; expected handoffs are queued and a negedge monitor checks them.
module tb_mem_resp_stage;
    logic        clk = 0, reset = 0, flush = 0, es_to_ms_valid = 0;
    logic [31:0] es_pc = 0, es_result = 0, data_rdata = 0;
    logic [4:0]  es_dest = 0;
    logic        es_gr_we = 0, es_mem_req = 0, es_load_op = 0, es_load_sign = 0, es_excp = 0;
    logic [1:0]  es_mem_size = 0;
    logic [15:0] es_excp_num = 0;
    logic        es_req_inflight = 0, data_data_ok = 0, ws_allowin = 1;
    logic        ms_allowin, ms_to_ws_valid, ms_gr_we, ms_excp, ms_fwd_valid, ms_fwd_blocked;
    logic [31:0] ms_pc, ms_final_result;
    logic [4:0]  ms_dest;
    logic [15:0] ms_excp_num;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  dest;
        logic        gr_we;
        logic        excp;
        logic [15:0] num;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;

    mem_resp_stage #(.DISCARD_W(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .es_to_ms_valid(es_to_ms_valid),
        .ms_allowin(ms_allowin), .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest),
        .es_gr_we(es_gr_we), .es_mem_req(es_mem_req), .es_load_op(es_load_op),
        .es_mem_size(es_mem_size), .es_load_sign(es_load_sign), .es_excp(es_excp),
        .es_excp_num(es_excp_num), .es_req_inflight(es_req_inflight),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we),
        .ms_excp(ms_excp), .ms_excp_num(ms_excp_num), .ms_final_result(ms_final_result),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_blocked(ms_fwd_blocked)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset && ms_to_ws_valid && ws_allowin) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_handoff: got pc=%h res=%h, required no handoff", ms_pc, ms_final_result);
            end else begin
                exp_t e, a;
                e = q.pop_front();
                a = '{ms_pc, ms_final_result, ms_dest, ms_gr_we, ms_excp, ms_excp_num};
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL handoff: got pc=%h res=%h dest=%0d we=%b ex=%b num=%h, required pc=%h res=%h dest=%0d we=%b ex=%b num=%h",
                             a.pc, a.res, a.dest, a.gr_we, a.excp, a.num, e.pc, e.res, e.dest, e.gr_we, e.excp, e.num);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic mem, input logic ld,
                         input logic [1:0] size, input logic sign, input logic ex, input logic [15:0] num);
        es_to_ms_valid = 1; es_pc = pc; es_result = addr; es_dest = pc[6:2];
        es_gr_we = ld || !mem; es_mem_req = mem; es_load_op = ld; es_mem_size = size;
        es_load_sign = sign; es_excp = ex; es_excp_num = num;
        step();
        es_to_ms_valid = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] res, input logic ex, input logic [15:0] num);
        exp_t e;
        e = '{pc, res, pc[6:2], 1'b1, ex, num};
        q.push_back(e);
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] addr, input logic [1:0] size, input logic sign,
                        input logic [31:0] rdata, input logic [31:0] exp, input int waits);
        push(pc, exp, 1'b0, 16'h0);
        issue(pc, addr, 1'b1, 1'b1, size, sign, 1'b0, 16'h0);
        repeat (waits) begin
            #2 chk("fwd_blocked_wait", 32'(ms_fwd_blocked), 32'd1);
            chk("no_handoff_wait", 32'(ms_to_ws_valid), 32'd0);
            step();
        end
        data_data_ok = 1; data_rdata = rdata;
        step();
        data_data_ok = 0;
        chk("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_allowin", 32'(ms_allowin), 32'd1);
        chk("rst_fwd_valid", 32'(ms_fwd_valid), 32'd0);
        chk("rst_fwd_blocked", 32'(ms_fwd_blocked), 32'd0);
        step(); step();
        reset = 1;
        step();
        // word load, byte/half extraction
        load(32'h100, 32'h1000, 2'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        load(32'h104, 32'h2002, 2'd0, 1'b1, 32'h12F45678, 32'hFFFFFFF4, 1);
        load(32'h108, 32'h2002, 2'd0, 1'b0, 32'h12F45678, 32'h000000F4, 0);
        load(32'h10C, 32'h2002, 2'd1, 1'b0, 32'h12F45678, 32'h000012F4, 0);
        load(32'h110, 32'h2001, 2'd0, 1'b0, 32'h12F45678, 32'h00000056, 0);
        load(32'h114, 32'h2000, 2'd1, 1'b1, 32'h12F48678, 32'hFFFF8678, 0);
        // response buffered while writeback stalls
        push(32'h300, 32'hCAFEF00D, 1'b0, 16'h0);
        issue(32'h300, 32'h3000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0);
        ws_allowin = 0; data_data_ok = 1; data_rdata = 32'hCAFEF00D;
        #2 chk("stall_allowin0", 32'(ms_allowin), 32'd0);
        step();
        data_data_ok = 0; data_rdata = 32'h11111111;
        #2 chk("stall_allowin1", 32'(ms_allowin), 32'd0);
        chk("stall_valid_held", 32'(ms_to_ws_valid), 32'd1);
        step();
        #2 chk("stall_allowin2", 32'(ms_allowin), 32'd0);
        step();
        ws_allowin = 1;
        step();
        chk("stall_drained", 32'(q.size()), 32'd0);
        // flush with a waiting load plus one request still in execute
        issue(32'h400, 32'h4000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0);
        flush = 1; es_req_inflight = 1;
        #2 chk("flush_no_handoff", 32'(ms_to_ws_valid), 32'd0);
        step();
        flush = 0; es_req_inflight = 0;
        push(32'h500, 32'h55555555, 1'b0, 16'h0);
        issue(32'h500, 32'h5000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0);
        data_data_ok = 1; data_rdata = 32'hBAD00001;
        #2 chk("drop1_no_handoff", 32'(ms_to_ws_valid), 32'd0);
        chk("drop1_blocked", 32'(ms_fwd_blocked), 32'd1);
        step();
        data_rdata = 32'hBAD00002;
        #2 chk("drop2_no_handoff", 32'(ms_to_ws_valid), 32'd0);
        step();
        data_rdata = 32'h55555555;
        step();
        data_data_ok = 0;
        chk("discard_drained", 32'(q.size()), 32'd0);
        // ALU ops back to back
        for (int i = 0; i < 3; i++) begin
            push(32'h600 + 32'(4 * i), 32'h55, 1'b0, 16'h0);
            issue(32'h600 + 32'(4 * i), 32'h55, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0);
            if (i < 2) es_to_ms_valid = 1;
            #2 chk("alu_fwd_valid", 32'(ms_fwd_valid), 32'd1);
            chk("alu_fwd_blocked", 32'(ms_fwd_blocked), 32'd0);
            chk("alu_allowin", 32'(ms_allowin), 32'd1);
        end
        es_to_ms_valid = 0;
        step();
        chk("alu_drained", 32'(q.size()), 32'd0);
        // exception: misaligned half load passes through without waiting
        push(32'h700, 32'h7001, 1'b1, 16'h0040);
        issue(32'h700, 32'h7001, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 16'h0040);
        step();
        chk("excp_drained", 32'(q.size()), 32'd0);
        // async reset while a load waits with one response pending discard
        issue(32'h900, 32'h9000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0);
        flush = 1;
        step();
        flush = 0;
        issue(32'h800, 32'h8000, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0);
        #2 chk("pre_reset_blocked", 32'(ms_fwd_blocked), 32'd1);
        reset = 0;
        #1 chk("reset_allowin", 32'(ms_allowin), 32'd1);
        chk("reset_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        chk("reset_fwd_blocked", 32'(ms_fwd_blocked), 32'd0);
        chk("reset_fwd_valid", 32'(ms_fwd_valid), 32'd0);
        step();
        reset = 1;
        #2 chk("post_reset_allowin", 32'(ms_allowin), 32'd1);
        step();
        load(32'hA00, 32'hA000, 2'd2, 1'b0, 32'h600DF00D, 32'h600DF00D, 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
